uart_rx_deserializer: RTL and testbench

Serial-to-parallel UART receiver for the SCI block. It is the line-side counterpart of the UART transmitter: it samples the `iUART_RXD` pin and recovers 8N1 frames (1 start bit, 8 data bits LSB first, 1 stop bit). Each good byte is presented as a one-cycle valid pulse for the RX FIFO write port, and framing errors are flagged for the SCI status/IRQ logic.

---
 rtl/uart_rx_deserializer.sv | 140 ++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver: 2-flop synchronizer, 3-sample majority vote per bit cell,
// one-cycle valid / framing-error pulses and a BREAK state that waits for the idle line.
module uart_rx_deserializer #(
   parameter logic [19:0] P_BAUDRATE_DIV = 20'd108
) (
   input  logic       iCLOCK,
   input  logic       inRESET,
   input  logic       iUART_RXD,
   output logic       oRX_VALID,
   output logic [7:0] oRX_DATA,
   output logic       oRX_FRAMING_ERR,
   output logic       oRX_BUSY
);

   localparam logic [19:0] HALF = P_BAUDRATE_DIV >> 1;
   localparam logic [19:0] LAST = P_BAUDRATE_DIV - 20'd1;
   // Captures are taken one edge before the counter reaches H-1 and H, so the
   // registered values line up with the decision edge where the counter reaches H+1.
   localparam logic [19:0] CAP0 = HALF - 20'd2;
   localparam logic [19:0] CAP1 = HALF - 20'd1;

   typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

   state_e      state_q, state_d;
   logic        sync1_q, rxd_s;
   logic [19:0] cnt_q, cnt_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic        s0_q, s0_d, s1_q, s1_d;
   logic        start_bad_q, start_bad_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        cell_wrap, decide, majority;

   always_ff @(posedge iCLOCK) begin
      if (!inRESET) begin
         sync1_q     <= 1'b1;
         rxd_s       <= 1'b1;
         state_q     <= StIdle;
         cnt_q       <= 20'd0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         s0_q        <= 1'b1;
         s1_q        <= 1'b1;
         start_bad_q <= 1'b0;
         data_q      <= 8'h00;
         valid_q     <= 1'b0;
         ferr_q      <= 1'b0;
      end else begin
         sync1_q     <= iUART_RXD;
         rxd_s       <= sync1_q;
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         s0_q        <= s0_d;
         s1_q        <= s1_d;
         start_bad_q <= start_bad_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         ferr_q      <= ferr_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      s0_d        = s0_q;
      s1_d        = s1_q;
      start_bad_d = start_bad_q;
      data_d      = data_q;
      valid_d     = 1'b0;
      ferr_d      = 1'b0;
      cell_wrap   = (cnt_q == LAST);
      decide      = (cnt_q == HALF);
      majority    = (s0_q & s1_q) | (s0_q & rxd_s) | (s1_q & rxd_s);

      if (state_q == StStart || state_q == StData || state_q == StStop) begin
         cnt_d = cell_wrap ? 20'd0 : cnt_q + 20'd1;
         if (cnt_q == CAP0) s0_d = rxd_s;
         if (cnt_q == CAP1) s1_d = rxd_s;
      end

      unique case (state_q)
         StIdle: begin
            cnt_d       = 20'd0;
            idx_d       = 3'd0;
            start_bad_d = 1'b0;
            if (!rxd_s) state_d = StStart;
         end
         StStart: begin
            if (start_bad_q) begin
               state_d = StIdle;
               cnt_d   = 20'd0;
            end else begin
               if (decide) start_bad_d = majority;
               if (cell_wrap) begin
                  state_d = StData;
                  idx_d   = 3'd0;
               end
            end
         end
         StData: begin
            if (decide) shift_d = {majority, shift_q[7:1]};
            if (cell_wrap) begin
               if (idx_q == 3'd7) state_d = StStop;
               else idx_d = idx_q + 3'd1;
            end
         end
         StStop: begin
            // Decide at mid-cell and leave at once so an early next start edge is caught.
            if (decide) begin
               cnt_d = 20'd0;
               if (majority) begin
                  data_d  = shift_q;
                  valid_d = 1'b1;
                  state_d = StIdle;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = StBreak;
               end
            end
         end
         StBreak: begin
            cnt_d = 20'd0;
            if (rxd_s) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   assign oRX_VALID       = valid_q;
   assign oRX_DATA        = data_q;
   assign oRX_FRAMING_ERR = ferr_q;
   assign oRX_BUSY        = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed and random line waveforms checked every cycle
// against a timing model built from the frame arithmetic, plus literal spot checks.
module tb_uart_rx_deserializer;

   localparam int D = 108;
   localparam int H = D / 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rxd = 1'b1;
   logic       valid, ferr, busy;
   logic [7:0] data;

   uart_rx_deserializer #(.P_BAUDRATE_DIV(20'(D))) dut (
      .iCLOCK         (clk),
      .inRESET        (rst_n),
      .iUART_RXD      (rxd),
      .oRX_VALID      (valid),
      .oRX_DATA       (data),
      .oRX_FRAMING_ERR(ferr),
      .oRX_BUSY       (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int n_vec = 0;
   int n_err = 0;
   int valid_count = 0;
   int ferr_count = 0;
   int last_valid_edge = 0;
   int e0_rec = 0;
   logic [7:0] got_q[$];

   // Model: line_h[e] is the line value sampled by edge e; the receiver sees it at e+2.
   logic line_h [0:65535];
   typedef enum {MIdle, MFrame, MBrk} mmode_e;
   mmode_e     m_mode = MIdle;
   int         m_e0 = 0;
   logic       m_start_bad = 1'b0;
   logic [7:0] m_shift = 8'h00;
   logic [7:0] m_data = 8'h00;
   logic       m_valid = 1'b0;
   logic       m_ferr = 1'b0;

   // Bit of cell starting at line index base-H: majority of line[base-1 .. base+1].
   function automatic logic maj_at(int base);
      logic a, b, c;
      a = line_h[base-1];
      b = line_h[base];
      c = line_h[base+1];
      return (a & b) | (a & c) | (b & c);
   endfunction

   initial begin
      int rel;
      line_h[0] = 1'b1;
      forever begin
         @(posedge clk);
         cyc++;
         if (cyc > 65535) begin
            $display("FAIL cycle_budget: cycle %0d exceeds limit 65535", cyc);
            $fatal(1);
         end
         line_h[cyc] = rxd;
         if (!rst_n) begin
            line_h[cyc]   = 1'b1;
            line_h[cyc-1] = 1'b1;
            m_mode  = MIdle;
            m_data  = 8'h00;
            m_shift = 8'h00;
            m_valid = 1'b0;
            m_ferr  = 1'b0;
         end else begin
            m_valid = 1'b0;
            m_ferr  = 1'b0;
            case (m_mode)
               MIdle: if (cyc >= 2 && line_h[cyc-2] == 1'b0) begin
                  m_e0 = cyc - 2;
                  m_mode = MFrame;
                  m_start_bad = 1'b0;
               end
               MFrame: begin
                  rel = cyc - m_e0;
                  if (rel == H + 3) m_start_bad = maj_at(m_e0 + H);
                  else if (rel == H + 4 && m_start_bad) m_mode = MIdle;
                  for (int n = 1; n <= 8; n++)
                     if (rel == n * D + H + 3) m_shift[n-1] = maj_at(m_e0 + n * D + H);
                  if (rel == 9 * D + H + 3) begin
                     if (maj_at(m_e0 + 9 * D + H)) begin
                        m_data  = m_shift;
                        m_valid = 1'b1;
                        m_mode  = MIdle;
                     end else begin
                        m_ferr = 1'b1;
                        m_mode = MBrk;
                     end
                  end
               end
               MBrk: if (line_h[cyc-2] == 1'b1) m_mode = MIdle;
               default: m_mode = MIdle;
            endcase
         end
      end
   end

   // Cycle-by-cycle compare, sampled on the falling edge.
   initial begin
      logic exp_busy;
      forever begin
         @(negedge clk);
         if (cyc >= 1) begin
            exp_busy = (m_mode != MIdle);
            n_vec++;
            if (valid !== m_valid || ferr !== m_ferr || busy !== exp_busy || data !== m_data) begin
               n_err++;
               $display("FAIL cycle_compare @edge %0d: dut valid/ferr/busy/data=%b/%b/%b/%h expected %b/%b/%b/%h",
                        cyc, valid, ferr, busy, data, m_valid, m_ferr, exp_busy, m_data);
            end
            if (valid === 1'b1) begin
               valid_count++;
               last_valid_edge = cyc;
               got_q.push_back(data);
            end
            if (ferr === 1'b1) ferr_count++;
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic hold(input logic v, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         rxd = v;
      end
   endtask

   // gcell 1..8 puts a 1-cycle inverted glitch into data bit gcell-1 at offset goff.
   task automatic send_frame(input logic [7:0] b, input logic stop, input int stop_len,
                             input int gcell, input int goff);
      @(negedge clk);
      rxd = 1'b0;
      e0_rec = cyc + 1;
      hold(1'b0, D - 1);
      for (int i = 0; i < 8; i++) begin
         if (gcell == i + 1) begin
            hold(b[i], goff);
            hold(~b[i], 1);
            hold(b[i], D - goff - 1);
         end else begin
            hold(b[i], D);
         end
      end
      hold(stop, stop_len);
   endtask

   initial begin
      int vc, fc, kind, gc;
      logic [7:0] rb;

      rst_n = 1'b0;
      rxd   = 1'b1;
      hold(1'b1, 3);
      #1;
      check("reset_valid", 32'(valid), 32'd0);
      check("reset_ferr", 32'(ferr), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_data", 32'(data), 32'h00);
      rst_n = 1'b1;
      hold(1'b1, 5);

      send_frame(8'hA5, 1'b1, D, 0, 0);
      hold(1'b1, 10);
      #1;
      check("good_valid_count", 32'(valid_count), 32'd1);
      check("good_valid_edge", 32'(last_valid_edge - e0_rec), 32'd1029);
      check("good_data", 32'(data), 32'hA5);
      check("good_busy_after", 32'(busy), 32'd0);
      check("good_no_ferr", 32'(ferr_count), 32'd0);

      vc = valid_count;
      fc = ferr_count;
      hold(1'b0, 20);
      hold(1'b1, 30);
      #1;
      check("false_start_busy_mid", 32'(busy), 32'd1);
      hold(1'b1, 40);
      #1;
      check("false_start_busy_end", 32'(busy), 32'd0);
      check("false_start_no_valid", 32'(valid_count), 32'(vc));
      check("false_start_no_ferr", 32'(ferr_count), 32'(fc));

      send_frame(8'h3C, 1'b0, D, 0, 0);
      hold(1'b0, 500);
      #1;
      check("ferr_single_pulse", 32'(ferr_count), 32'(fc + 1));
      check("ferr_data_kept", 32'(data), 32'hA5);
      check("ferr_busy_in_break", 32'(busy), 32'd1);
      check("ferr_no_valid", 32'(valid_count), 32'(vc));
      hold(1'b1, 10);
      #1;
      check("break_exit_busy", 32'(busy), 32'd0);
      hold(1'b1, 2 * D);
      #1;
      check("break_no_spurious", 32'(valid_count), 32'(vc));
      check("break_no_extra_ferr", 32'(ferr_count), 32'(fc + 1));

      vc = valid_count;
      send_frame(8'h00, 1'b1, D, 4, H);
      hold(1'b1, 1);
      send_frame(8'hFF, 1'b1, D, 0, 0);
      hold(1'b1, 1);
      send_frame(8'h81, 1'b1, D, 0, 0);
      hold(1'b1, 20);
      #1;
      check("b2b_valid_count", 32'(valid_count), 32'(vc + 3));
      if (got_q.size() >= 3) begin
         check("glitch_data", 32'(got_q[got_q.size()-3]), 32'h00);
         check("b2b_first", 32'(got_q[got_q.size()-2]), 32'hFF);
         check("b2b_second", 32'(got_q[got_q.size()-1]), 32'h81);
      end else begin
         check("b2b_history_size", 32'(got_q.size()), 32'd3);
      end

      vc = valid_count;
      rb = 8'h5A;
      @(negedge clk);
      rxd = 1'b0;
      hold(1'b0, D - 1);
      for (int i = 0; i < 4; i++) hold(rb[i], D);
      hold(rb[4], H);
      @(negedge clk);
      rst_n = 1'b0;
      rxd = 1'b1;
      hold(1'b1, 2);
      @(negedge clk);
      rst_n = 1'b1;
      hold(1'b1, 2 * D);
      #1;
      check("midreset_no_valid", 32'(valid_count), 32'(vc));
      check("midreset_busy", 32'(busy), 32'd0);
      check("midreset_data_cleared", 32'(data), 32'h00);
      send_frame(8'hC3, 1'b1, D, 0, 0);
      hold(1'b1, 20);
      #1;
      check("after_reset_data", 32'(data), 32'hC3);
      check("after_reset_valid_count", 32'(valid_count), 32'(vc + 1));

      for (int k = 0; k < 12; k++) begin
         kind = int'($urandom_range(0, 5));
         rb = 8'($urandom);
         gc = int'($urandom_range(0, 8));
         if (kind == 0) begin
            hold(1'b0, int'($urandom_range(1, H - 2)));
            hold(1'b1, int'($urandom_range(H + 5, D)));
         end else if (kind == 1) begin
            send_frame(rb, 1'b0, D, gc, int'($urandom_range(H - 1, H + 1)));
            hold(1'b0, int'($urandom_range(1, 300)));
            hold(1'b1, int'($urandom_range(3, 20)));
         end else begin
            send_frame(rb, 1'b1, int'($urandom_range(H + 2, D)), gc,
                       int'($urandom_range(H - 1, H + 1)));
            hold(1'b1, int'($urandom_range(0, 3)));
         end
      end
      hold(1'b1, 2 * D);
      #1;
      check("final_idle_busy", 32'(busy), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
